sha256_word_accumulator: RTL

Sequential multi-operand modulo-2^WIDTH adder for the SHA-256 datapath. Sums a stream of up to NUM_OPS words per transaction, e.g. T1 = h + Sigma1 + Ch + K + W. Operands enter over a valid/ready input port, one per cycle. The truncated sum is returned over a valid/ready output port.
- Addition uses a parametrised group carry-lookahead adder, the successor to the per-bit full-adder cell with g/p outputs.
- The block sits between the message-schedule/round-function logic and the working-variable registers.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_word_accumulator_if.sv | 51 +++++
 rtl/sha256_cla_adder.sv | 65 ++++++
 rtl/sha256_word_accumulator.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 word accumulator slice.
// Holds the datapath word width, the accumulator FSM state encoding and
// the default sizing parameters used by the accumulator and its adder.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_NUM_OPS = 5;
    localparam int DEF_GROUP   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/sha256_word_accumulator_if.sv
// Operand-in / sum-out handshake bundle for sha256_word_accumulator.
// master = producer/consumer side, slave = the accumulator itself.
// Optional macro SHA256_ACC_OVERFLOW_EN adds the carry-count signal.
interface sha256_word_accumulator_if
    import sha256_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = $clog2(DEF_NUM_OPS + 1)
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;
`ifdef SHA256_ACC_OVERFLOW_EN
    logic [CNT_W-1:0] overflow;
`endif

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  sum,
        input  out_count,
        input  out_valid,
`ifdef SHA256_ACC_OVERFLOW_EN
        input  overflow,
`endif
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output sum,
        output out_count,
        output out_valid,
`ifdef SHA256_ACC_OVERFLOW_EN
        output overflow,
`endif
        input  out_ready
    );

endinterface

// File: rtl/sha256_cla_adder.sv
// Combinational group carry-lookahead adder.
// Each GROUP-bit group computes its internal carries directly from the
// per-bit generate/propagate terms and the group carry-in; group carries
// then ripple from one group to the next.
module sha256_cla_adder
    import sha256_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int GROUP = DEF_GROUP
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out
);

    localparam int NUM_GROUPS = WIDTH / GROUP;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;
    logic             w_prod;
    logic             w_any;

    // Per-bit generate and propagate terms.
    always_comb begin
        w_g = i_a & i_b;
        w_p = i_a ^ i_b;
    end

    // Lookahead carries inside each group, rippling the group carry-out onward.
    always_comb begin
        w_c    = '0;
        w_prod = 1'b0;
        w_any  = 1'b0;
        w_c[0] = i_carry_in;
        for (int grp = 0; grp < NUM_GROUPS; grp++) begin
            for (int j = 1; j <= GROUP; j++) begin
                w_any = 1'b0;
                // Carries generated at bit k and propagated through bits k+1..j-1.
                for (int k = 0; k < j; k++) begin
                    w_prod = w_g[grp*GROUP + k];
                    for (int m = k + 1; m < j; m++) begin
                        w_prod = w_prod & w_p[grp*GROUP + m];
                    end
                    w_any = w_any | w_prod;
                end
                // Group carry-in propagated through bits 0..j-1.
                w_prod = w_c[grp*GROUP];
                for (int m = 0; m < j; m++) begin
                    w_prod = w_prod & w_p[grp*GROUP + m];
                end
                w_c[grp*GROUP + j] = w_any | w_prod;
            end
        end
    end

    // Sum bits and final carry-out.
    always_comb begin
        o_result    = w_p ^ w_c[WIDTH-1:0];
        o_carry_out = w_c[WIDTH];
    end

endmodule

// File: rtl/sha256_word_accumulator.sv
// Sequential multi-operand modulo-2^WIDTH adder (e.g. T1 = h+S1+Ch+K+W).
// Accepts up to NUM_OPS operands per transaction over a valid/ready input,
// then presents the truncated sum and operand count on a valid/ready output.
// Optional macro SHA256_ACC_OVERFLOW_EN: counts carries out of the MSB.
module sha256_word_accumulator
    import sha256_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int GROUP   = DEF_GROUP
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    sha256_word_accumulator_if.slave      bus
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ACC  = ACC;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_ovf;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_ovf_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_cla_sum;
    logic             w_cla_cout;

    sha256_cla_adder #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) u_cla (
        .i_a         (r_acc),
        .i_b         (bus.in_data),
        .i_carry_in  (1'b0),
        .o_result    (w_cla_sum),
        .o_carry_out (w_cla_cout)
    );

    // Handshake qualifiers and next-state/datapath decisions.
    always_comb begin
        w_in_hs     = bus.in_valid & r_in_ready;
        w_out_hs    = r_out_valid & bus.out_ready;
        w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_acc_nxt   = bus.in_data;
                    w_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                    w_ovf_nxt   = '0;
                    if (bus.in_last || (NUM_OPS == 32'sd1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_ACC;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC: begin
                if (w_in_hs) begin
                    w_acc_nxt   = w_cla_sum;
                    w_count_nxt = w_count_inc;
                    if (w_cla_cout) begin
                        w_ovf_nxt = r_ovf + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_ovf_nxt = r_ovf;
                    end
                    // Full operand budget forces the result out even without InLast.
                    if (bus.in_last || (w_count_inc == CNT_W'(NUM_OPS))) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_ACC;
                    end
                end else begin
                    w_state_nxt = S_ACC;
                end
            end
            S_HOLD: begin
                if (w_out_hs) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // State, accumulator and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_ovf       <= w_ovf_nxt;
            r_in_ready  <= (w_state_nxt != S_HOLD);
            r_out_valid <= (w_state_nxt == S_HOLD);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_acc;
    assign bus.out_count = r_count;

`ifdef SHA256_ACC_OVERFLOW_EN
    assign bus.overflow = r_ovf;
`else
    // Carry count is not exported in this build; keep the nets tied off.
    logic             w_unused_cout;
    logic [CNT_W-1:0] w_unused_ovf;
    assign w_unused_cout = w_cla_cout;
    assign w_unused_ovf  = r_ovf;
`endif

endmodule
